// File: rtl/sin_rom_pkg.sv
// ============================================================================
// Module      : sin_rom_pkg
// Description : Widths, quarter-wave sine table and sign/mirror decode helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package sin_rom_pkg;

    localparam int          ADDR_W   = 4;
    localparam int          DATA_W   = 8;
    localparam logic [7:0]  MIDSCALE = 8'd128;

    // round(127*sin(n*22.5deg)) for n = 0..4
    localparam logic [7:0] Q [0:4] = '{8'd0, 8'd49, 8'd90, 8'd117, 8'd127};

    function automatic logic signed [8:0] signed_mag(input logic [ADDR_W-1:0] a);
        logic [2:0] i;
        logic [2:0] q;
        logic [8:0] m;
        i = a[2:0];
        q = (i <= 3'd4) ? i : 3'(4'd8 - {1'b0, i});
        m = {1'b0, Q[q]};
        return a[3] ? -$signed(m) : $signed(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sin_rom_if.sv
// ============================================================================
// Module      : sin_rom_if
// Description : Phase address in, registered sine sample out.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface sin_rom_if;
    import sin_rom_pkg::*;

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;

    modport master (output addr, input  dout);
    modport slave  (input  addr, output dout);
endinterface

`default_nettype wire

// File: rtl/sin_rom.sv
// ============================================================================
// Module      : sin_rom
// Description : 16-entry sine LUT, offset binary, one-cycle registered output.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sin_rom
    import sin_rom_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    sin_rom_if.slave   bus
);

    logic [8:0]        sum_d;
    logic [DATA_W-1:0] dout_d;
    logic [DATA_W-1:0] dout_q;

    // Result always lies in 1..255, so dropping the ninth bit loses nothing.
    always_comb begin
        sum_d  = {1'b0, MIDSCALE} + signed_mag(bus.addr);
        dout_d = 8'(sum_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q <= MIDSCALE;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign bus.dout = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_sin_rom.sv
// ============================================================================
// Module      : tb_sin_rom
// Description : Directed and random checks of the sine LUT against a fixed table.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_sin_rom;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    sin_rom_if bus ();

    sin_rom dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] c_tab [0:15] = '{8'd128, 8'd177, 8'd218, 8'd245, 8'd255, 8'd245, 8'd218, 8'd177,
                                 8'd128, 8'd79,  8'd38,  8'd11,  8'd1,   8'd11,  8'd38,  8'd79};
    logic [7:0] obs [0:15];

    task automatic step(input logic [3:0] a, input logic rn);
        @(negedge clk);
        bus.addr = a;
        rst_n    = rn;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        n_assert++;
        assert (bus.dout === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, bus.dout, exp);
        end
    endtask

    initial begin
        bus.addr = 4'd4;

        // Reset held low for three edges with addr = 4
        for (int c = 0; c < 3; c++) begin
            step(4'd4, 1'b0);
            chk("reset_hold", 8'd128);
        end
        step(4'd4, 1'b1);
        chk("reset_release", 8'd255);

        // Full sweep
        for (int k = 0; k < 16; k++) begin
            step(4'(k), 1'b1);
            obs[k] = bus.dout;
            chk($sformatf("sweep_k%0d", k), c_tab[k]);
        end

        // Wrap 15 -> 0, then hold
        for (int c = 0; c < 3; c++) begin
            step(4'd0, 1'b1);
            chk($sformatf("wrap_hold_%0d", c), 8'd128);
        end

        // Extremes
        step(4'd4, 1'b1);
        chk("peak_addr4", 8'd255);
        step(4'd12, 1'b1);
        chk("trough_addr12", 8'd1);

        // Half-cycle symmetry
        for (int k = 0; k < 8; k++) begin
            n_assert++;
            assert ((int'(obs[k]) + int'(obs[k+8])) === 256) else begin
                n_fail++;
                $error("FAIL symmetry_k%0d: observed %0d expected 256", k,
                       int'(obs[k]) + int'(obs[k+8]));
            end
        end

        // Reset in the middle of a sweep
        step(4'd5, 1'b1);
        chk("midsweep_k5", 8'd245);
        step(4'd6, 1'b0);
        chk("midsweep_reset", 8'd128);
        step(4'd7, 1'b1);
        chk("midsweep_after", 8'd177);

        // Random addresses, one per cycle
        for (int r = 0; r < 1000; r++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            step(a, 1'b1);
            chk($sformatf("random_%0d_addr%0d", r, a), c_tab[a]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
